// File: rtl/tlc_output_monitor.sv
// tlc_output_monitor: observes the traffic-light outputs, decodes the countdown and flags protocol errors
module tlc_output_monitor #(
    parameter int unsigned TICK_DIV = 100_000_000,
    parameter int unsigned RED_S    = 9,
    parameter int unsigned GREEN_S  = 7,
    parameter int unsigned YELLOW_S = 3,
    parameter int unsigned TOL_CYC  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        red_led,
    input  logic        green_led,
    input  logic        yellow_led,
    input  logic [6:0]  seg,
    input  logic        clear,
    output logic [1:0]  phase,
    output logic [3:0]  digit,
    output logic        digit_valid,
    output logic        phase_done,
    output logic [31:0] last_dur,
    output logic        err_combo,
    output logic        err_order,
    output logic        err_seg,
    output logic        err_count,
    output logic        err_dur,
    output logic        err_any
);
    localparam logic [1:0] S_OFF    = 2'd0;
    localparam logic [1:0] S_RED    = 2'd1;
    localparam logic [1:0] S_GREEN  = 2'd2;
    localparam logic [1:0] S_YELLOW = 2'd3;
    localparam logic [39:0] RED_EXP    = 40'(RED_S) * 40'(TICK_DIV);
    localparam logic [39:0] GREEN_EXP  = 40'(GREEN_S) * 40'(TICK_DIV);
    localparam logic [39:0] YELLOW_EXP = 40'(YELLOW_S) * 40'(TICK_DIV);

    logic        r_red_q, r_grn_q, r_yel_q, r_clr_q;
    logic [6:0]  r_seg_q;
    logic [1:0]  r_phase;
    logic [31:0] r_cnt;
    logic [31:0] r_last;
    logic        r_done;
    logic [3:0]  r_digit;
    logic        r_dv;
    logic        r_ref;
    logic        r_err_combo, r_err_order, r_err_seg, r_err_count, r_err_dur;

    logic [1:0]  w_n_lit;
    logic        w_combo;
    logic [1:0]  w_obs;
    logic        w_change;
    logic        w_legal;
    logic        w_exit;
    logic [39:0] w_exp;
    logic [39:0] w_cnt40;
    logic [39:0] w_diff;
    logic        w_dur_bad;
    logic        w_seg_ok;
    logic [3:0]  w_seg_dig;
    logic        w_blank;
    logic        w_bad_seg;
    logic        w_count_bad;

    assign w_n_lit   = {1'b0, r_red_q} + {1'b0, r_grn_q} + {1'b0, r_yel_q};
    assign w_combo   = w_n_lit > 2'd1;
    assign w_obs     = r_red_q ? S_RED : r_grn_q ? S_GREEN : r_yel_q ? S_YELLOW : S_OFF;
    assign w_change  = !w_combo && (w_obs != r_phase);
    assign w_legal   = (w_obs == S_OFF) ||
                       (r_phase == S_OFF    && w_obs == S_RED)   ||
                       (r_phase == S_RED    && w_obs == S_GREEN) ||
                       (r_phase == S_GREEN  && w_obs == S_YELLOW) ||
                       (r_phase == S_YELLOW && w_obs == S_RED);
    // Leaving OFF is not the end of a real phase, so only lit-to-lit exits complete one
    assign w_exit    = w_change && (r_phase != S_OFF) && (w_obs != S_OFF);
    assign w_exp     = (r_phase == S_RED) ? RED_EXP : (r_phase == S_GREEN) ? GREEN_EXP : YELLOW_EXP;
    assign w_cnt40   = {8'd0, r_cnt};
    assign w_diff    = (w_cnt40 >= w_exp) ? (w_cnt40 - w_exp) : (w_exp - w_cnt40);
    assign w_dur_bad = w_exit && (w_diff > 40'(TOL_CYC));
    assign w_blank   = r_seg_q == 7'h00;
    assign w_bad_seg = !w_seg_ok && !w_blank;
    // A digit right after a phase entry or a blank has no reference to count down from
    assign w_count_bad = w_seg_ok && !w_change && r_ref &&
                         (w_seg_dig != r_digit) && (w_seg_dig != r_digit - 4'd1);

    // Seven-segment {g,f,e,d,c,b,a} to digit lookup
    always_comb begin
        w_seg_ok  = 1'b1;
        w_seg_dig = 4'd0;
        case (r_seg_q)
            7'h3F: w_seg_dig = 4'd0;
            7'h06: w_seg_dig = 4'd1;
            7'h5B: w_seg_dig = 4'd2;
            7'h4F: w_seg_dig = 4'd3;
            7'h66: w_seg_dig = 4'd4;
            7'h6D: w_seg_dig = 4'd5;
            7'h7D: w_seg_dig = 4'd6;
            7'h07: w_seg_dig = 4'd7;
            7'h7F: w_seg_dig = 4'd8;
            7'h6F: w_seg_dig = 4'd9;
            default: w_seg_ok = 1'b0;
        endcase
    end

    // Single register stage on every observed input
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_red_q <= 1'b0;
            r_grn_q <= 1'b0;
            r_yel_q <= 1'b0;
            r_clr_q <= 1'b0;
            r_seg_q <= 7'h00;
        end else begin
            r_red_q <= red_led;
            r_grn_q <= green_led;
            r_yel_q <= yellow_led;
            r_clr_q <= clear;
            r_seg_q <= seg;
        end
    end

    // Phase tracking, saturating duration counter and completed-phase reporting
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase <= S_OFF;
            r_cnt   <= 32'd0;
            r_last  <= 32'd0;
            r_done  <= 1'b0;
        end else begin
            r_phase <= w_change ? w_obs : r_phase;
            r_cnt   <= w_change ? 32'd1 : (&r_cnt) ? r_cnt : r_cnt + 32'd1;
            r_last  <= w_exit ? r_cnt : r_last;
            r_done  <= w_exit;
        end
    end

    // Digit capture and countdown reference tracking
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_digit <= 4'd0;
            r_dv    <= 1'b0;
            r_ref   <= 1'b0;
        end else begin
            r_digit <= w_seg_ok ? w_seg_dig : r_digit;
            r_dv    <= w_seg_ok;
            r_ref   <= w_seg_ok ? 1'b1 : (w_blank || w_change) ? 1'b0 : r_ref;
        end
    end

    // Sticky error flags; a new error outranks a simultaneous clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_combo <= 1'b0;
            r_err_order <= 1'b0;
            r_err_seg   <= 1'b0;
            r_err_count <= 1'b0;
            r_err_dur   <= 1'b0;
        end else begin
            r_err_combo <= (r_err_combo && !r_clr_q) || w_combo;
            r_err_order <= (r_err_order && !r_clr_q) || (w_change && !w_legal);
            r_err_seg   <= (r_err_seg && !r_clr_q) || w_bad_seg;
            r_err_count <= (r_err_count && !r_clr_q) || w_count_bad;
            r_err_dur   <= (r_err_dur && !r_clr_q) || w_dur_bad;
        end
    end

    assign phase       = r_phase;
    assign digit       = r_digit;
    assign digit_valid = r_dv;
    assign phase_done  = r_done;
    assign last_dur    = r_last;
    assign err_combo   = r_err_combo;
    assign err_order   = r_err_order;
    assign err_seg     = r_err_seg;
    assign err_count   = r_err_count;
    assign err_dur     = r_err_dur;
    assign err_any     = r_err_combo | r_err_order | r_err_seg | r_err_count | r_err_dur;
endmodule

// File: tb/tb_tlc_output_monitor.sv
// tb_tlc_output_monitor: directed and randomized checks of tlc_output_monitor against a behavioural model
module tb_tlc_output_monitor;
    localparam int TICK = 10;
    localparam int TOL  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        red_led = 1'b0, green_led = 1'b0, yellow_led = 1'b0, clear = 1'b0;
    logic [6:0]  seg = 7'h00;
    logic [1:0]  phase;
    logic [3:0]  digit;
    logic        digit_valid, phase_done;
    logic [31:0] last_dur;
    logic        err_combo, err_order, err_seg, err_count, err_dur, err_any;

    int n_vec = 0;
    int n_err = 0;
    bit go = 1'b0;
    logic [31:0] dq[$];

    int         secs[4]   = '{0, 9, 7, 3};
    int         nxt[4]    = '{1, 2, 3, 1};
    logic [6:0] codes[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    tlc_output_monitor #(.TICK_DIV(TICK), .RED_S(9), .GREEN_S(7), .YELLOW_S(3), .TOL_CYC(TOL)) dut (
        .clk(clk), .reset(reset), .red_led(red_led), .green_led(green_led), .yellow_led(yellow_led),
        .seg(seg), .clear(clear), .phase(phase), .digit(digit), .digit_valid(digit_valid),
        .phase_done(phase_done), .last_dur(last_dur), .err_combo(err_combo), .err_order(err_order),
        .err_seg(err_seg), .err_count(err_count), .err_dur(err_dur), .err_any(err_any)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  ph;
        logic [31:0] len;
        logic [31:0] last;
        logic [3:0]  dig;
        logic        dv, done, has_ref;
        logic        ec, eo, es, ect, ed;
        logic        r, g, y, c;
        logic [6:0]  sg;
    } mst_t;

    mst_t m = '0;

    // One observed cycle: s holds the outputs so far plus the sample taken at the previous edge
    function automatic mst_t step(input mst_t s, input logic r, input logic g, input logic y,
                                  input logic c, input logic [6:0] sg);
        mst_t n;
        int lit, obs, d;
        bit chg, n_ec, n_eo, n_es, n_ect, n_ed;
        longint e, df;
        n = s;
        lit = int'(s.r) + int'(s.g) + int'(s.y);
        obs = s.r ? 1 : s.g ? 2 : s.y ? 3 : 0;
        chg = (lit <= 1) && (obs != int'(s.ph));
        n_ec = lit > 1;
        n_eo = chg && obs != 0 && obs != nxt[s.ph];
        n.done = chg && s.ph != 2'd0 && obs != 0;
        n_ed = 1'b0;
        if (n.done) begin
            n.last = s.len;
            e = longint'(secs[s.ph]) * longint'(TICK);
            df = longint'(s.len) - e;
            if (df < 0) df = -df;
            n_ed = df > longint'(TOL);
        end
        n.len = chg ? 32'd1 : (s.len == 32'hFFFF_FFFF) ? s.len : s.len + 32'd1;
        if (chg) n.ph = 2'(obs);
        d = -1;
        for (int k = 0; k < 10; k++) if (codes[k] == s.sg) d = k;
        n_es = 1'b0;
        n_ect = 1'b0;
        if (d >= 0) begin
            n_ect = !chg && s.has_ref && d != int'(s.dig) && d != int'(s.dig) - 1;
            n.dig = 4'(d);
            n.dv = 1'b1;
            n.has_ref = 1'b1;
        end else begin
            n.dv = 1'b0;
            if (s.sg == 7'h00) n.has_ref = 1'b0;
            else begin
                n_es = 1'b1;
                if (chg) n.has_ref = 1'b0;
            end
        end
        n.ec  = (s.ec && !s.c) || n_ec;
        n.eo  = (s.eo && !s.c) || n_eo;
        n.es  = (s.es && !s.c) || n_es;
        n.ect = (s.ect && !s.c) || n_ect;
        n.ed  = (s.ed && !s.c) || n_ed;
        n.r = r; n.g = g; n.y = y; n.c = c; n.sg = sg;
        return n;
    endfunction

    always @(posedge clk or negedge reset)
        m <= !reset ? '0 : step(m, red_led, green_led, yellow_led, clear, seg);

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        logic [50:0] act, exp_v;
        if (go) begin
            act = {phase, digit, digit_valid, phase_done, last_dur, err_combo, err_order, err_seg, err_count, err_dur, err_any};
            exp_v = {m.ph, m.dig, m.dv, m.done, m.last, m.ec, m.eo, m.es, m.ect, m.ed, m.ec | m.eo | m.es | m.ect | m.ed};
            n_vec++;
            if (act !== exp_v) begin
                n_err++;
                $display("FAIL cycle_compare t=%0t got=%h want=%h", $time, act, exp_v);
            end
        end
        if (phase_done) dq.push_back(last_dur);
    end

    task automatic chk(input string name, input longint act, input longint want);
        n_vec++;
        if (act != want) begin
            n_err++;
            $display("FAIL %s got=%0d want=%0d", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic lamps(input int ph);
        red_led = ph == 1;
        green_led = ph == 2;
        yellow_led = ph == 3;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        lamps(0);
        seg = 7'h00;
        clear = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        dq.delete();
    endtask

    task automatic hold(input int ph, input int cyc);
        lamps(ph);
        repeat (cyc) tick();
    endtask

    // Phase with a countdown display, occasional corrupt or blank codes and random clears
    task automatic run_phase(input int ph, input int cyc);
        lamps(ph);
        for (int i = 0; i < cyc; i++) begin
            seg = codes[((cyc - 1 - i) / TICK) % 10];
            if ($urandom % 48 == 0) seg = 7'($urandom);
            if ($urandom % 40 == 0) seg = 7'h00;
            clear = ($urandom % 64) == 0;
            tick();
        end
        clear = 1'b0;
    endtask

    initial begin
        int ph, k;
        tick();
        go = 1'b1;
        do_reset();
        chk("reset_phase", phase, 0);
        chk("reset_last_dur", last_dur, 0);
        chk("reset_err_any", err_any, 0);

        // nominal red/green/yellow cycle
        hold(1, 90); hold(2, 70); hold(3, 30); hold(1, 3);
        chk("nom_pulses", dq.size(), 3);
        if (dq.size() == 3) begin
            chk("nom_red_dur", dq[0], 90);
            chk("nom_green_dur", dq[1], 70);
            chk("nom_yellow_dur", dq[2], 30);
        end
        chk("nom_phase", phase, 1);
        chk("nom_err_any", err_any, 0);

        // green too long, then green within tolerance
        do_reset();
        hold(1, 90); hold(2, 75); lamps(3); tick();
        chk("dur75_pre", err_dur, 0);
        tick();
        chk("dur75_err", err_dur, 1);
        do_reset();
        hold(1, 90); hold(2, 73); hold(3, 3);
        chk("dur73_err", err_dur, 0);

        // two lamps at once, then an illegal order
        do_reset();
        hold(1, 10);
        red_led = 1'b1; green_led = 1'b1; tick();
        lamps(1); tick();
        chk("combo_err", err_combo, 1);
        chk("combo_phase", phase, 1);
        do_reset();
        hold(1, 10); hold(3, 2);
        chk("order_err", err_order, 1);
        chk("order_phase", phase, 3);

        // segment decode and countdown
        do_reset();
        seg = 7'h6F; tick(); tick();
        chk("seg9", digit, 9);
        chk("seg9_valid", digit_valid, 1);
        seg = 7'h7F; tick(); tick();
        chk("seg8", digit, 8);
        seg = 7'h07; tick(); tick();
        chk("seg7", digit, 7);
        chk("seg7_err_any", err_any, 0);
        seg = 7'h05; tick(); tick();
        chk("seg_bad_err", err_seg, 1);
        chk("seg_bad_digit", digit, 7);
        chk("seg_bad_valid", digit_valid, 0);
        seg = 7'h7D; tick(); tick();
        chk("seg6_count", err_count, 0);
        seg = 7'h6D; tick(); tick();
        chk("seg5_count", err_count, 0);
        seg = 7'h07; tick(); tick();
        chk("seg_up_count", err_count, 1);

        // clear, abort to OFF, re-entry
        clear = 1'b1; tick(); clear = 1'b0; tick();
        chk("clear_err_any", err_any, 0);
        seg = 7'h00;
        dq.delete();
        hold(1, 90); hold(2, 20); hold(0, 2);
        chk("abort_phase", phase, 0);
        chk("abort_pulses", dq.size(), 1);
        chk("abort_last_dur", last_dur, 90);
        hold(1, 2);
        chk("reentry_order", err_order, 0);
        chk("reentry_phase", phase, 1);

        // reset in the middle of red
        do_reset();
        seg = 7'h4F;
        hold(1, 40);
        reset = 1'b0;
        #1;
        chk("midrst_phase", phase, 0);
        chk("midrst_digit", digit, 0);
        chk("midrst_valid", digit_valid, 0);
        chk("midrst_last", last_dur, 0);
        chk("midrst_err_any", err_any, 0);
        tick();
        seg = 7'h00;
        reset = 1'b1;
        hold(2, 2);
        chk("post_rst_order", err_order, 1);
        chk("post_rst_phase", phase, 2);

        // randomized sequences
        do_reset();
        ph = 1;
        repeat (40) begin
            k = int'($urandom % 16);
            if (k == 0) begin
                run_phase(0, int'($urandom_range(1, 5)));
                ph = 1;
            end else if (k == 1) ph = int'($urandom_range(1, 3));
            else if (k == 2) begin
                red_led = 1'b1; green_led = 1'b1; yellow_led = 1'($urandom);
                tick();
            end
            run_phase(ph, secs[ph] * TICK + int'($urandom_range(0, 12)) - 6);
            ph = (ph == 3) ? 1 : ph + 1;
        end
        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
